// File: rtl/pwls_sched_pkg.sv
// Shared types for the PWLS channel scheduler: config field addresses, FSM states
// and the packed per-channel parameter record.
`ifndef CHANNEL_MODE_BITS
`define CHANNEL_MODE_BITS 2
`endif

package pwls_sched_pkg;

  localparam int BITS_DEF        = 12;
  localparam int OCT_BITS        = 3;
  localparam int DETUNE_EXP_BITS = 3;
  localparam int SLOPE_EXP_BITS  = 4;
  localparam int MANT_BITS       = BITS_DEF - 1;
  localparam int AMP_BITS        = BITS_DEF - 2;
  localparam int MODE_BITS       = `CHANNEL_MODE_BITS;

  localparam logic [1:0] ADDR_FREQ   = 2'd0;
  localparam logic [1:0] ADDR_DETUNE = 2'd1;
  localparam logic [1:0] ADDR_SLOPE  = 2'd2;
  localparam logic [1:0] ADDR_AMP    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [OCT_BITS-1:0]        octave;
    logic [MANT_BITS-1:0]       mantissa;
    logic [DETUNE_EXP_BITS-1:0] detune_exp;
    logic [MANT_BITS-1:0]       tri_offset;
    logic [SLOPE_EXP_BITS-1:0]  slope_exp;
    logic [MANT_BITS-1:0]       slope_offset;
    logic [MODE_BITS-1:0]       channel_mode;
    logic [AMP_BITS-1:0]        amp;
  } ch_params_t;

  localparam ch_params_t PARAMS_RST = '{
    octave: '0, mantissa: '0, detune_exp: '0, tri_offset: '0,
    slope_exp: '0, slope_offset: '0, channel_mode: '0, amp: '1
  };

endpackage

// File: rtl/pwls_sched_regfile.sv
// Per-channel parameter storage: one field-select write port, one async read port.
// Reads see the pre-write contents in the cycle a write lands (read-before-write).
module pwls_sched_regfile
  import pwls_sched_pkg::*;
#(
  parameter int NUM_CHANNELS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            we,
  input  logic [$clog2(NUM_CHANNELS)-1:0] wr_ch,
  input  logic [1:0]                      wr_addr,
  input  logic [15:0]                     wr_data,
  input  logic [$clog2(NUM_CHANNELS)-1:0] rd_ch,
  output ch_params_t                      rd_data
);

  ch_params_t mem_q [NUM_CHANNELS];
  logic       unused_hi;

  assign unused_hi = wr_data[15];
  assign rd_data   = mem_q[rd_ch];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) mem_q[i] <= PARAMS_RST;
    end else if (we) begin
      case (wr_addr)
        ADDR_FREQ:   {mem_q[wr_ch].octave, mem_q[wr_ch].mantissa}
                       <= wr_data[OCT_BITS+MANT_BITS-1:0];
        ADDR_DETUNE: {mem_q[wr_ch].detune_exp, mem_q[wr_ch].tri_offset}
                       <= wr_data[DETUNE_EXP_BITS+MANT_BITS-1:0];
        ADDR_SLOPE:  {mem_q[wr_ch].slope_exp, mem_q[wr_ch].slope_offset}
                       <= wr_data[SLOPE_EXP_BITS+MANT_BITS-1:0];
        default:     {mem_q[wr_ch].channel_mode, mem_q[wr_ch].amp}
                       <= wr_data[MODE_BITS+AMP_BITS-1:0];
      endcase
    end
  end

endmodule

// File: rtl/pwls_channel_scheduler.sv
// Frame sequencer sharing one channel ALU across NUM_CHANNELS slots per sample_tick.
// Define PWLS_SCHED_CHANNEL_MASK_EN to add a per-channel enable mask (cfg_sel port).
module pwls_channel_scheduler
  import pwls_sched_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int BITS            = 12,
  parameter int OCT_BITS        = 3,
  parameter int DETUNE_EXP_BITS = 3,
  parameter int SLOPE_EXP_BITS  = 4,
  parameter int SLOT_CYCLES     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sample_tick,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_CHANNELS)-1:0] cfg_channel,
  input  logic [1:0]                      cfg_addr,
  input  logic [15:0]                     cfg_data,
`ifdef PWLS_SCHED_CHANNEL_MASK_EN
  input  logic                            cfg_sel,
`endif
  output logic                            busy,
  output logic                            alu_start,
  output logic [$clog2(NUM_CHANNELS)-1:0] cur_channel,
  output logic [$clog2(SLOT_CYCLES)-1:0]  slot_phase,
  output logic [OCT_BITS-1:0]             octave,
  output logic [BITS-2:0]                 mantissa,
  output logic [DETUNE_EXP_BITS-1:0]      detune_exp,
  output logic [BITS-2:0]                 tri_offset,
  output logic [SLOPE_EXP_BITS-1:0]       slope_exp,
  output logic [BITS-2:0]                 slope_offset,
  output logic [BITS-3:0]                 amp,
  output logic [`CHANNEL_MODE_BITS-1:0]   channel_mode,
  output logic                            frame_done,
  output logic                            overrun
);

  localparam int CW = $clog2(NUM_CHANNELS);
  localparam int PW = $clog2(SLOT_CYCLES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(SLOT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cur_ch_q, ch_d, rd_ch;
  logic [PW-1:0]   phase_q, phase_d;
  logic            start_q, start_d;
  logic            overrun_q, overrun_d;
  logic            load;
  ch_params_t      params_q, rd_data;

  logic [NUM_CHANNELS-1:0] en_mask;
  logic                    rf_we;

`ifdef PWLS_SCHED_CHANNEL_MASK_EN
  logic [NUM_CHANNELS-1:0] mask_q;
  logic                    mask_wr;

  // cfg_sel steers the ch0/addr3 slot to the mask instead of the amp field
  assign mask_wr = cfg_we & cfg_sel & (cfg_channel == '0) & (cfg_addr == ADDR_AMP);
  assign rf_we   = cfg_we & ~cfg_sel;
  assign en_mask = mask_q;

  always_ff @(posedge clk) begin
    if (reset)        mask_q <= '1;
    else if (mask_wr) mask_q <= cfg_data[NUM_CHANNELS-1:0];
  end
`else
  assign rf_we   = cfg_we;
  assign en_mask = '1;
`endif

  pwls_sched_regfile #(.NUM_CHANNELS(NUM_CHANNELS)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .wr_ch   (cfg_channel),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_ch   (rd_ch),
    .rd_data (rd_data)
  );

  // Lowest enabled channel overall, and lowest enabled channel above the current one
  logic          first_found, nxt_found;
  logic [CW-1:0] first_ch, nxt_ch;

  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (en_mask[i]) begin
        first_found = 1'b1;
        first_ch    = CW'(i);
        if (i > int'(cur_ch_q)) begin
          nxt_found = 1'b1;
          nxt_ch    = CW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = cur_ch_q;
    phase_d   = phase_q;
    start_d   = 1'b0;
    overrun_d = overrun_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          if (first_found) begin
            state_d = S_RUN;
            ch_d    = first_ch;
            phase_d = '0;
            start_d = 1'b1;
            load    = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (sample_tick) overrun_d = 1'b1;
        if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          if (nxt_found) begin
            ch_d    = nxt_ch;
            start_d = 1'b1;
            load    = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_DONE: begin
        if (sample_tick) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rd_ch = ch_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_ch_q  <= '0;
      phase_q   <= '0;
      start_q   <= 1'b0;
      overrun_q <= 1'b0;
      params_q  <= PARAMS_RST;
    end else begin
      state_q   <= state_d;
      cur_ch_q  <= ch_d;
      phase_q   <= phase_d;
      start_q   <= start_d;
      overrun_q <= overrun_d;
      if (load) params_q <= rd_data;
    end
  end

  assign busy         = (state_q == S_RUN);
  assign frame_done   = (state_q == S_DONE);
  assign alu_start    = start_q;
  assign cur_channel  = cur_ch_q;
  assign slot_phase   = phase_q;
  assign overrun      = overrun_q;
  assign octave       = params_q.octave;
  assign mantissa     = params_q.mantissa;
  assign detune_exp   = params_q.detune_exp;
  assign tri_offset   = params_q.tri_offset;
  assign slope_exp    = params_q.slope_exp;
  assign slope_offset = params_q.slope_offset;
  assign amp          = params_q.amp;
  assign channel_mode = params_q.channel_mode;

endmodule

// File: tb/tb_pwls_channel_scheduler.sv
// Directed self-checking bench for pwls_channel_scheduler (default 4 ch x 8 cycles).
module tb_pwls_channel_scheduler;

  logic        clk = 1'b0;
  logic        reset, sample_tick, cfg_we;
  logic [1:0]  cfg_channel, cfg_addr;
  logic [15:0] cfg_data;
`ifdef PWLS_SCHED_CHANNEL_MASK_EN
  logic        cfg_sel;
`endif
  logic        busy, alu_start, frame_done, overrun;
  logic [1:0]  cur_channel;
  logic [2:0]  slot_phase;
  logic [2:0]  octave, detune_exp;
  logic [10:0] mantissa, tri_offset, slope_offset;
  logic [3:0]  slope_exp;
  logic [9:0]  amp;
  logic [1:0]  channel_mode;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwls_channel_scheduler dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .cfg_we(cfg_we),
    .cfg_channel(cfg_channel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`ifdef PWLS_SCHED_CHANNEL_MASK_EN
    .cfg_sel(cfg_sel),
`endif
    .busy(busy), .alu_start(alu_start), .cur_channel(cur_channel),
    .slot_phase(slot_phase), .octave(octave), .mantissa(mantissa),
    .detune_exp(detune_exp), .tri_offset(tri_offset), .slope_exp(slope_exp),
    .slope_offset(slope_offset), .amp(amp), .channel_mode(channel_mode),
    .frame_done(frame_done), .overrun(overrun)
  );

  typedef struct {
    int         cyc;
    logic       busy, start;
    logic [1:0] ch;
    logic [2:0] ph;
    logic       done;
    logic       pos;
  } tl_t;

  typedef struct {
    logic [1:0]  ch, addr;
    logic [15:0] data;
    logic [15:0] ea, eb;
  } pv_t;

  tl_t tl[12];
  pv_t pv[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0;
    cfg_channel = '0; cfg_addr = '0; cfg_data = '0;
`ifdef PWLS_SCHED_CHANNEL_MASK_EN
    cfg_sel = 1'b0;
`endif
    step(2);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_channel = ch; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  // Leaves the bench at cycle 1 of the new frame
  task automatic start_frame();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (frame_done) seen = 1'b1;
      else step();
    end
    chk("frame_done_within_bound", 32'(seen), 32'd1);
    step();
  endtask

  function automatic logic [15:0] fld_a(input logic [1:0] a);
    case (a)
      2'd0:    return 16'(octave);
      2'd1:    return 16'(detune_exp);
      2'd2:    return 16'(slope_exp);
      default: return 16'(channel_mode);
    endcase
  endfunction

  function automatic logic [15:0] fld_b(input logic [1:0] a);
    case (a)
      2'd0:    return 16'(mantissa);
      2'd1:    return 16'(tri_offset);
      2'd2:    return 16'(slope_offset);
      default: return 16'(amp);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;
    tl[0]  = '{0,  1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1};
    tl[1]  = '{1,  1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1};
    tl[2]  = '{2,  1'b1, 1'b0, 2'd0, 3'd1, 1'b0, 1'b1};
    tl[3]  = '{8,  1'b1, 1'b0, 2'd0, 3'd7, 1'b0, 1'b1};
    tl[4]  = '{9,  1'b1, 1'b1, 2'd1, 3'd0, 1'b0, 1'b1};
    tl[5]  = '{16, 1'b1, 1'b0, 2'd1, 3'd7, 1'b0, 1'b1};
    tl[6]  = '{17, 1'b1, 1'b1, 2'd2, 3'd0, 1'b0, 1'b1};
    tl[7]  = '{24, 1'b1, 1'b0, 2'd2, 3'd7, 1'b0, 1'b1};
    tl[8]  = '{25, 1'b1, 1'b1, 2'd3, 3'd0, 1'b0, 1'b1};
    tl[9]  = '{32, 1'b1, 1'b0, 2'd3, 3'd7, 1'b0, 1'b1};
    tl[10] = '{33, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0};
    tl[11] = '{34, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0};

    pv[0] = '{2'd2, 2'd0, 16'h1ABC, 16'h3, 16'h2BC};
    pv[1] = '{2'd0, 2'd1, 16'hFFFF, 16'h7, 16'h7FF};
    pv[2] = '{2'd3, 2'd2, 16'hDA5A, 16'hB, 16'h25A};
    pv[3] = '{2'd1, 2'd3, 16'hFC01, 16'h3, 16'h001};

    // Reset state and one full frame timeline
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_octave", 32'(octave), 0);
    chk("rst_mantissa", 32'(mantissa), 0);
    chk("rst_slope_exp", 32'(slope_exp), 0);
    chk("rst_amp", 32'(amp), 32'h3FF);
    k = 0;
    sample_tick = 1'b1;
    for (int c = 0; c <= 34; c++) begin
      if (k < 12 && tl[k].cyc == c) begin
        chk($sformatf("tl%0d_busy", c), 32'(busy), 32'(tl[k].busy));
        chk($sformatf("tl%0d_alu_start", c), 32'(alu_start), 32'(tl[k].start));
        chk($sformatf("tl%0d_frame_done", c), 32'(frame_done), 32'(tl[k].done));
        if (tl[k].pos) begin
          chk($sformatf("tl%0d_cur_channel", c), 32'(cur_channel), 32'(tl[k].ch));
          chk($sformatf("tl%0d_slot_phase", c), 32'(slot_phase), 32'(tl[k].ph));
        end
        if (c == 1) chk("tl1_amp_default", 32'(amp), 32'h3FF);
        k++;
      end
      step();
      sample_tick = 1'b0;
    end

    // Field packing per register, held across the slot, not leaking to the next channel
    for (int i = 0; i < 4; i++) begin
      cfg_write(pv[i].ch, pv[i].addr, pv[i].data);
      start_frame();
      step(8 * int'(pv[i].ch));
      chk($sformatf("pv%0d_a_start", i), 32'(fld_a(pv[i].addr)), 32'(pv[i].ea));
      chk($sformatf("pv%0d_b_start", i), 32'(fld_b(pv[i].addr)), 32'(pv[i].eb));
      step(7);
      chk($sformatf("pv%0d_b_slot_end", i), 32'(fld_b(pv[i].addr)), 32'(pv[i].eb));
      if (pv[i].ch != 2'd3) begin
        step();
        chk($sformatf("pv%0d_a_next_ch", i), 32'(fld_a(pv[i].addr)), 0);
      end
      wait_done();
    end

    // Mid-slot write to the active channel takes effect on its next slot
    do_reset();
    start_frame();
    step(12);
    chk("mid_cur_channel", 32'(cur_channel), 1);
    chk("mid_slot_phase", 32'(slot_phase), 4);
    cfg_write(2'd1, 2'd3, 16'h0155);
    chk("mid_amp_held_c14", 32'(amp), 32'h3FF);
    step(2);
    chk("mid_amp_held_c16", 32'(amp), 32'h3FF);
    wait_done();
    start_frame();
    step(8);
    chk("mid_amp_next_frame", 32'(amp), 32'h155);
    wait_done();

    // Overrun: tick mid-frame, tick in DONE, earliest accepted tick
    do_reset();
    start_frame();
    step(9);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_busy", 32'(busy), 1);
    chk("ovr_cur_channel", 32'(cur_channel), 1);
    chk("ovr_slot_phase", 32'(slot_phase), 2);
    step(22);
    chk("ovr_frame_done_c33", 32'(frame_done), 1);
    chk("ovr_sticky", 32'(overrun), 1);
    step();
    chk("ovr_idle_busy", 32'(busy), 0);

    do_reset();
    start_frame();
    step(32);
    chk("done_tick_frame_done", 32'(frame_done), 1);
    chk("done_tick_pre_overrun", 32'(overrun), 0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("done_tick_overrun", 32'(overrun), 1);
    chk("done_tick_busy", 32'(busy), 0);
    chk("done_tick_start", 32'(alu_start), 0);

    do_reset();
    start_frame();
    step(33);
    chk("early_idle_done", 32'(frame_done), 0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("early_busy", 32'(busy), 1);
    chk("early_start", 32'(alu_start), 1);
    chk("early_overrun", 32'(overrun), 0);
    wait_done();

    // Reset mid-frame aborts without frame_done and restores defaults
    do_reset();
    cfg_write(2'd1, 2'd3, 16'h00AA);
    start_frame();
    step(11);
    chk("abort_amp_c12", 32'(amp), 32'h0AA);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cur_channel", 32'(cur_channel), 0);
    chk("abort_slot_phase", 32'(slot_phase), 0);
    chk("abort_amp", 32'(amp), 32'h3FF);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (frame_done) cnt++;
      step();
    end
    chk("abort_no_frame_done", 32'(cnt), 0);
    start_frame();
    step(8);
    chk("abort_regfile_amp", 32'(amp), 32'h3FF);
    wait_done();

`ifdef PWLS_SCHED_CHANNEL_MASK_EN
    // Channel mask: skip disabled slots; empty mask goes straight to DONE
    do_reset();
    cfg_sel = 1'b1;
    cfg_write(2'd0, 2'd3, 16'h0005);
    cfg_sel = 1'b0;
    start_frame();
    chk("mask_c1_start", 32'(alu_start), 1);
    chk("mask_c1_ch", 32'(cur_channel), 0);
    chk("mask_c1_amp", 32'(amp), 32'h3FF);
    step(8);
    chk("mask_c9_start", 32'(alu_start), 1);
    chk("mask_c9_ch", 32'(cur_channel), 2);
    step(8);
    chk("mask_c17_done", 32'(frame_done), 1);
    chk("mask_c17_busy", 32'(busy), 0);
    step();
    cfg_sel = 1'b1;
    cfg_write(2'd0, 2'd3, 16'h0000);
    cfg_sel = 1'b0;
    start_frame();
    chk("mask0_done", 32'(frame_done), 1);
    chk("mask0_busy", 32'(busy), 0);
    chk("mask0_start", 32'(alu_start), 0);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
